// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: opcode, operand, address and result.
package instr_register_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned OPND_W = 32;
   localparam int unsigned RES_W  = 64;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [OPND_W-1:0] operand_t;
   typedef logic        [ADDR_W-1:0] address_t;
   typedef logic        [ADDR_W:0]   count_t;
   typedef logic signed [RES_W-1:0]  result_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational executor: one instruction word in, signed result and error flag out.
module instr_alu
   import instr_register_pkg::*;
(
   input  instruction_t iw,
   output result_t      result_c,
   output logic         err_c
);

   result_t a;
   result_t b;

   // Sign-extend operands to result width, then apply the opcode.
   always_comb begin
      a        = RES_W'(iw.op_a);
      b        = RES_W'(iw.op_b);
      result_c = '0;
      err_c    = 1'b0;
      case (iw.opc)
         ZERO:  result_c = '0;
         PASSA: result_c = a;
         PASSB: result_c = b;
         ADD:   result_c = a + b;
         SUB:   result_c = a - b;
         MULT:  result_c = a * b;
         DIV: begin
            if (b == '0) err_c = 1'b1;
            else         result_c = a / b;
         end
         MOD: begin
            if (b == '0) err_c = 1'b1;
            else         result_c = a % b;
         end
         default: result_c = '0;
      endcase
   end

endmodule

// File: rtl/instr_reader.sv
// Read side of the instruction register: walks a slot window, executes each
// instruction and hands results out on a valid/ready channel.
module instr_reader
   import instr_register_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  address_t     start_addr,
   input  count_t       count,
   output address_t     read_pointer,
   input  instruction_t instruction_word,
   output logic         res_valid,
   input  logic         res_ready,
   output result_t      result,
   output opcode_t      res_opcode,
   output address_t     res_index,
   output logic         res_err,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      EXEC  = 3'd3,
      OUT   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t       state;
   count_t       remaining;
   instruction_t iw_q;
   result_t      alu_result_c;
   logic         alu_err_c;

   instr_alu u_alu (
      .iw       (iw_q),
      .result_c (alu_result_c),
      .err_c    (alu_err_c)
   );

   // Run sequencer: fetch, latch, execute, then hold the result until accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         remaining    <= '0;
         iw_q         <= '0;
         read_pointer <= '0;
         res_valid    <= 1'b0;
         result       <= '0;
         res_opcode   <= ZERO;
         res_index    <= '0;
         res_err      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (count != '0) begin
                     read_pointer <= start_addr;
                     remaining    <= count;
                     state        <= FETCH;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            FETCH: state <= LATCH;
            LATCH: begin
               iw_q  <= instruction_word;
               state <= EXEC;
            end
            EXEC: begin
               result     <= alu_result_c;
               res_opcode <= iw_q.opc;
               res_index  <= read_pointer;
               res_err    <= alu_err_c;
               res_valid  <= 1'b1;
               state      <= OUT;
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  remaining <= remaining - count_t'(1);
                  if (remaining == count_t'(1)) begin
                     state <= DONE;
                  end else begin
                     read_pointer <= read_pointer + address_t'(1);
                     state        <= FETCH;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_reader.sv
// Bench for instr_reader: register model, result scoreboard and directed runs.
module tb_instr_reader;
   import instr_register_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   address_t     start_addr;
   count_t       count;
   address_t     read_pointer;
   instruction_t instruction_word;
   logic         res_valid;
   logic         res_ready;
   result_t      result;
   opcode_t      res_opcode;
   address_t     res_index;
   logic         res_err;
   logic         busy;
   logic         done;

   instr_reader dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .start_addr       (start_addr),
      .count            (count),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .result           (result),
      .res_opcode       (res_opcode),
      .res_index        (res_index),
      .res_err          (res_err),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   // Instruction register with one-cycle read latency.
   instruction_t mem [DEPTH];
   always @(posedge clk) instruction_word <= mem[read_pointer];

   typedef struct {
      longint   r;
      bit       e;
      opcode_t  opc;
      address_t idx;
   } exp_t;

   exp_t   expq[$];
   longint got_res[$];
   int     got_idx[$];
   bit     got_err[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     done_seen = 0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Arithmetic as stated: operands widened to 64 bits, DIV/MOD by zero flagged.
   function automatic void model(input instruction_t iw, output longint r, output bit e);
      longint a;
      longint b;
      a = longint'(iw.op_a);
      b = longint'(iw.op_b);
      r = 0;
      e = 1'b0;
      case (iw.opc)
         PASSA: r = a;
         PASSB: r = b;
         ADD:   r = a + b;
         SUB:   r = a - b;
         MULT:  r = a * b;
         DIV:   if (b == 0) e = 1'b1; else r = a / b;
         MOD:   if (b == 0) e = 1'b1; else r = a % b;
         default: r = 0;
      endcase
   endfunction

   // Scoreboard: every accepted result against the model, held results must not move.
   bit       have_prev = 1'b0;
   result_t  p_res;
   address_t p_idx;
   opcode_t  p_opc;
   logic     p_err;
   always @(negedge clk) begin
      if (!reset_n) begin
         have_prev = 1'b0;
      end else begin
         if (done) done_seen++;
         if (res_valid) begin
            chk("rp_eq_index", read_pointer, res_index);
            if (have_prev) begin
               chk("hold_result", result, p_res);
               chk("hold_index", res_index, p_idx);
               chk("hold_opcode", res_opcode, p_opc);
               chk("hold_err", res_err, p_err);
            end
            if (res_ready) begin
               if (expq.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  exp_t ex;
                  ex = expq.pop_front();
                  chk("result", result, ex.r);
                  chk("res_err", res_err, 64'(ex.e));
                  chk("res_opcode", res_opcode, ex.opc);
                  chk("res_index", res_index, ex.idx);
               end
               got_res.push_back(longint'(result));
               got_idx.push_back(int'(res_index));
               got_err.push_back(res_err);
               have_prev = 1'b0;
            end else begin
               have_prev = 1'b1;
               p_res = result;
               p_idx = res_index;
               p_opc = res_opcode;
               p_err = res_err;
            end
         end else begin
            have_prev = 1'b0;
         end
      end
   end

   task automatic run(input address_t sa, input count_t n);
      longint r;
      bit     e;
      for (int i = 0; i < int'(n); i++) begin
         address_t s;
         s = address_t'(int'(sa) + i);
         model(mem[s], r, e);
         expq.push_back('{r: r, e: e, opc: mem[s].opc, idx: s});
      end
      got_res.delete();
      got_idx.delete();
      got_err.delete();
      start_addr = sa;
      count      = n;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input bit rnd_ready, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_rp"}, read_pointer, 0);
      chk({name, "_valid"}, res_valid, 0);
      chk({name, "_result"}, result, 0);
      chk({name, "_opcode"}, res_opcode, ZERO);
      chk({name, "_index"}, res_index, 0);
      chk({name, "_err"}, res_err, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_done"}, done, 0);
   endtask

   initial begin
      longint t2r[3];
      int     t2i[3];
      for (int s = 0; s < int'(DEPTH); s++) mem[s] = '0;
      reset_n    = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      count      = '0;
      res_ready  = 1'b0;
      #1 check_reset_values("por");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Single ADD: latency and done timing.
      mem[0] = '{opc: ADD, op_a: 5, op_b: -7};
      res_ready = 1'b1;
      run(5'd0, 6'd1);
      chk("t1_busy", busy, 1);
      repeat (2) @(posedge clk);
      #1 chk("t1_valid_early", res_valid, 0);
      @(posedge clk);
      #1;
      chk("t1_valid", res_valid, 1);
      chk("t1_result", result, -2);
      chk("t1_index", res_index, 0);
      chk("t1_err", res_err, 0);
      @(posedge clk);
      #1 chk("t1_done_e4", done, 0);
      @(posedge clk);
      #1;
      chk("t1_done_e5", done, 1);
      chk("t1_busy_end", busy, 0);
      @(posedge clk);
      #1 chk("t1_done_e6", done, 0);

      // Window wrapping 30,31,0.
      mem[30] = '{opc: MULT, op_a: -3, op_b: 4};
      mem[31] = '{opc: SUB, op_a: 10, op_b: 20};
      mem[0]  = '{opc: PASSB, op_a: 0, op_b: 99};
      run(5'd30, 6'd3);
      wait_done(1'b0, "t2");
      t2r = '{-12, -10, 99};
      t2i = '{30, 31, 0};
      chk("t2_count", got_res.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("t2_res_lit", got_res[i], t2r[i]);
         chk("t2_idx_lit", got_idx[i], t2i[i]);
      end

      // DIV by zero then MOD with negative dividend.
      mem[4] = '{opc: DIV, op_a: 7, op_b: 0};
      mem[5] = '{opc: MOD, op_a: -7, op_b: 2};
      run(5'd4, 6'd2);
      wait_done(1'b0, "t3");
      chk("t3_count", got_res.size(), 2);
      chk("t3_res0", got_res[0], 0);
      chk("t3_err0", got_err[0], 1);
      chk("t3_res1", got_res[1], -1);
      chk("t3_err1", got_err[1], 0);

      // Backpressure for 10 cycles with a stray start in the middle.
      mem[10] = '{opc: ADD, op_a: 100, op_b: 23};
      mem[11] = '{opc: PASSA, op_a: -5, op_b: 0};
      res_ready = 1'b0;
      run(5'd10, 6'd2);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("t4_valid", res_valid, 1);
         chk("t4_result", result, 123);
         chk("t4_index", res_index, 10);
         if (i == 4) begin
            start_addr = 5'd20;
            count      = 6'd5;
            start      = 1'b1;
         end
         if (i == 5) start = 1'b0;
         @(posedge clk);
         #1;
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_rp_next", read_pointer, 11);
      chk("t4_valid_drop", res_valid, 0);
      wait_done(1'b0, "t4");
      chk("t4_count", got_res.size(), 2);
      chk("t4_res1", got_res[1], -5);

      // Empty run: done pulse, no reads, no results.
      run(5'd7, 6'd0);
      chk("t5_busy", busy, 1);
      @(posedge clk);
      #1;
      chk("t5_done", done, 1);
      chk("t5_rp", read_pointer, 11);
      chk("t5_busy_end", busy, 0);
      repeat (3) @(posedge clk);
      #1 chk("t5_valid", res_valid, 0);

      // Full 32-slot window from 17 with random backpressure.
      for (int s = 0; s < int'(DEPTH); s++)
         mem[s] = '{opc: opcode_t'(s % 8), op_a: operand_t'(s * 1000 - 7777),
                    op_b: operand_t'(s % 5 - 2)};
      run(5'd17, 6'd32);
      wait_done(1'b1, "t6");
      res_ready = 1'b1;
      chk("t6_count", got_idx.size(), 32);
      for (int i = 0; i < 32; i++) chk("t6_idx_seq", got_idx[i], (17 + i) % 32);

      // Reset while a result is waiting.
      mem[3] = '{opc: MULT, op_a: -100000, op_b: 300000};
      res_ready = 1'b0;
      run(5'd3, 6'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("t7_valid", res_valid, 1);
      chk("t7_result", result, -64'sd30000000000);
      #1 reset_n = 1'b0;
      #1 check_reset_values("t7_rst");
      expq.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      res_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t7_idle_busy", busy, 0);
      chk("t7_idle_valid", res_valid, 0);
      chk("t7_idle_rp", read_pointer, 0);

      chk("done_pulses", done_seen, 6);
      chk("queue_drained", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
